// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared defaults, IF/ID layout and update-rule decode for the fetch stage
//
// Purpose: parameter defaults for the fetch stage, the IF/ID field layout,
//          and the priority decode of the per-edge update rule.
// Ports:   none (package).
package if_stage_pkg;

  localparam int unsigned XLEN_DEF        = 32;
  localparam int unsigned ILEN_DEF        = 32;
  localparam int unsigned INSTR_BYTES_DEF = 4;
  localparam logic [31:0] RESET_PC_DEF    = 32'h0000_0000;

  // IF/ID layout: {pc, instr}. The instruction occupies the low ILEN bits and
  // the PC sits directly above it in the upper XLEN bits.
  localparam int unsigned IFID_INSTR_LSB = 0;

  // Which rule governs the next rising edge, in priority order.
  typedef enum logic [2:0] {
    UPD_RESET,
    UPD_REDIRECT,
    UPD_STALL,
    UPD_GRANT,
    UPD_IDLE
  } upd_e;

  // Source of the next PC value (reset is applied directly in the register).
  typedef enum logic [1:0] {
    PC_HOLD,
    PC_REDIRECT,
    PC_INC
  } pc_sel_e;

  function automatic upd_e decode_update(
    input logic reset,
    input logic redirect_en,
    input logic id_stall,
    input logic igrant
  );
    if (reset)            return UPD_RESET;
    else if (redirect_en) return UPD_REDIRECT;
    else if (id_stall)    return UPD_STALL;
    else if (igrant)      return UPD_GRANT;
    else                  return UPD_IDLE;
  endfunction

endpackage

// File: rtl/if_stage_pc_gen.sv
// rtl/if_stage_pc_gen.sv - program counter register and next-PC selection
//
// Purpose: holds the PC and selects its next value (reset / aligned redirect /
//          hold / increment by INSTR_BYTES, modulo 2^XLEN).
// Ports:
//   clk           in   clock
//   reset         in   synchronous active-high reset, loads RESET_PC
//   i_upd         in   update rule for this edge
//   i_redirect_pc in   redirect target (low bits masked to instruction alignment)
//   o_pc          out  current PC
module pc_gen
  import if_stage_pkg::*;
#(
  parameter int unsigned      XLEN        = XLEN_DEF,
  parameter int unsigned      INSTR_BYTES = INSTR_BYTES_DEF,
  parameter logic [XLEN-1:0]  RESET_PC    = XLEN'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            reset,
  input  upd_e            i_upd,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic [XLEN-1:0] o_pc
);

  // INSTR_BYTES is a power of two, so clearing the low bits is a simple mask.
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INSTR_BYTES - 1));
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INSTR_BYTES);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_next_pc;
  pc_sel_e         w_sel;

  always_comb begin
    w_sel = PC_HOLD;
    case (i_upd)
      UPD_REDIRECT: w_sel = PC_REDIRECT;
      UPD_GRANT:    w_sel = PC_INC;
      default:      w_sel = PC_HOLD;
    endcase
  end

  // Increment relies on natural XLEN-bit wraparound.
  always_comb begin
    w_next_pc = r_pc;
    case (w_sel)
      PC_REDIRECT: w_next_pc = i_redirect_pc & ALIGN_MASK;
      PC_INC:      w_next_pc = r_pc + PC_STEP;
      default:     w_next_pc = r_pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_next_pc;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with IF/ID pipeline register
//
// Purpose: issues fetch requests at the PC, captures granted instructions
//          into the IF/ID register one cycle later, handles stall and
//          redirect (flush), and counts delivered instructions.
// Ports:
//   clk          in   clock
//   reset        in   synchronous active-high reset
//   idata        in   instruction word for iaddr, valid when igrant=1
//   igrant       in   memory accepted the request this cycle
//   id_stall     in   decode cannot accept; hold IF/ID
//   redirect_en  in   taken branch/jump; flush and reload PC
//   redirect_pc  in   redirect target
//   ireq         out  fetch request
//   iaddr        out  fetch address (= PC)
//   reg_if_id    out  {pc, instr}
//   if_id_valid  out  IF/ID holds a real instruction
//   fetch_count  out  instructions delivered since reset (wraps)
module if_stage
  import if_stage_pkg::*;
#(
  parameter int unsigned      XLEN        = XLEN_DEF,
  parameter int unsigned      ILEN        = ILEN_DEF,
  parameter int unsigned      INSTR_BYTES = INSTR_BYTES_DEF,
  parameter logic [XLEN-1:0]  RESET_PC    = XLEN'(RESET_PC_DEF)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ILEN-1:0]      idata,
  input  logic                 igrant,
  input  logic                 id_stall,
  input  logic                 redirect_en,
  input  logic [XLEN-1:0]      redirect_pc,
  output logic                 ireq,
  output logic [XLEN-1:0]      iaddr,
  output logic [XLEN+ILEN-1:0] reg_if_id,
  output logic                 if_id_valid,
  output logic [31:0]          fetch_count
);

  upd_e                 w_upd;
  logic [XLEN-1:0]      w_pc;
  logic [XLEN+ILEN-1:0] r_if_id;
  logic                 r_if_id_valid;
  logic [31:0]          r_fetch_count;

  assign w_upd = decode_update(reset, redirect_en, id_stall, igrant);

  pc_gen #(
    .XLEN        (XLEN),
    .INSTR_BYTES (INSTR_BYTES),
    .RESET_PC    (RESET_PC)
  ) u_pc_gen (
    .clk           (clk),
    .reset         (reset),
    .i_upd         (w_upd),
    .i_redirect_pc (redirect_pc),
    .o_pc          (w_pc)
  );

  // A request is only useful when its result can actually be captured:
  // not under reset, not while decode is stalled, not while being flushed.
  assign ireq  = ~reset & ~id_stall & ~redirect_en;
  assign iaddr = w_pc;

  // A redirect drops whatever the memory returns this cycle, so the
  // wrong-path instruction never reaches IF/ID with valid set.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_if_id       <= '0;
      r_if_id_valid <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      case (w_upd)
        UPD_REDIRECT: begin
          r_if_id_valid <= 1'b0;
        end
        UPD_GRANT: begin
          r_if_id[XLEN+ILEN-1 -: XLEN]             <= w_pc;
          r_if_id[IFID_INSTR_LSB +: ILEN]          <= idata;
          r_if_id_valid                            <= 1'b1;
          r_fetch_count                            <= r_fetch_count + 32'd1;
        end
        UPD_IDLE: begin
          r_if_id_valid <= 1'b0;
        end
        default: begin
          // Stall: everything holds.
        end
      endcase
    end
  end

  assign reg_if_id   = r_if_id;
  assign if_id_valid = r_if_id_valid;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage
module tb_if_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] idata;
  logic        igrant;
  logic        id_stall;
  logic        redirect_en;
  logic [31:0] redirect_pc;

  logic        ireq,  ireq_80;
  logic [31:0] iaddr, iaddr_80;
  logic [63:0] reg_if_id, reg_if_id_80;
  logic        if_id_valid, if_id_valid_80;
  logic [31:0] fetch_count, fetch_count_80;

  if_stage u_dut (
    .clk         (clk),
    .reset       (reset),
    .idata       (idata),
    .igrant      (igrant),
    .id_stall    (id_stall),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .ireq        (ireq),
    .iaddr       (iaddr),
    .reg_if_id   (reg_if_id),
    .if_id_valid (if_id_valid),
    .fetch_count (fetch_count)
  );

  if_stage #(.RESET_PC(32'h0000_0080)) u_dut_80 (
    .clk         (clk),
    .reset       (reset),
    .idata       (idata),
    .igrant      (igrant),
    .id_stall    (id_stall),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .ireq        (ireq_80),
    .iaddr       (iaddr_80),
    .reg_if_id   (reg_if_id_80),
    .if_id_valid (if_id_valid_80),
    .fetch_count (fetch_count_80)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        red;
    logic [31:0] rpc;
    logic        stall;
    logic        gnt;
    logic [31:0] data;
    logic        chk_addr;
    logic        exp_ireq;
    logic [31:0] exp_iaddr;
    logic [31:0] exp_pc;
    logic        exp_v;
    logic [31:0] exp_ifpc;
    logic [31:0] exp_ifin;
    logic [31:0] exp_cnt;
  } vec_t;

  typedef struct {
    int          tag;
    logic [31:0] pc;
    logic        v;
    logic [63:0] ifid;
    logic [31:0] cnt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic row(input logic rst, red, input logic [31:0] rpc, input logic stall, gnt,
                     input logic [31:0] data, input logic chk_addr, exp_ireq,
                     input logic [31:0] exp_iaddr, exp_pc, input logic exp_v,
                     input logic [31:0] exp_ifpc, exp_ifin, exp_cnt);
    vec_t v;
    v.rst = rst; v.red = red; v.rpc = rpc; v.stall = stall; v.gnt = gnt; v.data = data;
    v.chk_addr = chk_addr; v.exp_ireq = exp_ireq; v.exp_iaddr = exp_iaddr;
    v.exp_pc = exp_pc; v.exp_v = exp_v; v.exp_ifpc = exp_ifpc; v.exp_ifin = exp_ifin;
    v.exp_cnt = exp_cnt;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, red, input logic [31:0] rpc, input logic stall, gnt,
                       input logic [31:0] data);
    @(negedge clk);
    reset = rst; redirect_en = red; redirect_pc = rpc;
    id_stall = stall; igrant = gnt; idata = data;
  endtask

  task automatic edge_and_compare();
    exp_t e;
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty actual=0 required=1");
    end else begin
      checks--;
      e = sb.pop_front();
      check($sformatf("pc[%0d]", e.tag), {32'h0, iaddr}, {32'h0, e.pc});
      check($sformatf("valid[%0d]", e.tag), {63'h0, if_id_valid}, {63'h0, e.v});
      check($sformatf("if_id[%0d]", e.tag), reg_if_id, e.ifid);
      check($sformatf("count[%0d]", e.tag), {32'h0, fetch_count}, {32'h0, e.cnt});
    end
  endtask

  logic [31:0] m_pc, m_cnt;
  logic [63:0] m_ifid;
  logic        m_v;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    exp_t e;
    reset = 1'b1; redirect_en = 1'b0; redirect_pc = '0;
    id_stall = 1'b0; igrant = 1'b0; idata = '0;

    //   rst red rpc           stl gnt data          chk ireq iaddr         pc            v  ifpc          ifin          cnt
    row(1, 0, 32'h0,         0, 1, 32'h0,        0, 0, 32'h0,         32'h0,        0, 32'h0,        32'h0,  0);
    row(0, 0, 32'h0,         0, 1, 32'h11,       1, 1, 32'h0,         32'h4,        1, 32'h0,        32'h11, 1);
    row(0, 0, 32'h0,         0, 1, 32'h22,       1, 1, 32'h4,         32'h8,        1, 32'h4,        32'h22, 2);
    row(0, 0, 32'h0,         0, 1, 32'h33,       1, 1, 32'h8,         32'hC,        1, 32'h8,        32'h33, 3);
    row(1, 0, 32'h0,         0, 0, 32'h0,        0, 0, 32'h0,         32'h0,        0, 32'h0,        32'h0,  0);
    row(0, 0, 32'h0,         0, 1, 32'h11,       1, 1, 32'h0,         32'h4,        1, 32'h0,        32'h11, 1);
    row(0, 0, 32'h0,         0, 1, 32'h22,       1, 1, 32'h4,         32'h8,        1, 32'h4,        32'h22, 2);
    row(0, 0, 32'h0,         1, 1, 32'h99,       1, 0, 32'h8,         32'h8,        1, 32'h4,        32'h22, 2);
    row(0, 0, 32'h0,         1, 1, 32'h98,       1, 0, 32'h8,         32'h8,        1, 32'h4,        32'h22, 2);
    row(0, 0, 32'h0,         1, 0, 32'h97,       1, 0, 32'h8,         32'h8,        1, 32'h4,        32'h22, 2);
    row(0, 0, 32'h0,         0, 1, 32'h33,       1, 1, 32'h8,         32'hC,        1, 32'h8,        32'h33, 3);
    row(0, 1, 32'h103,       1, 1, 32'hAA,       1, 0, 32'hC,         32'h100,      0, 32'h8,        32'h33, 3);
    row(0, 0, 32'h0,         0, 1, 32'hBB,       1, 1, 32'h100,       32'h104,      1, 32'h100,      32'hBB, 4);
    row(1, 0, 32'h0,         0, 1, 32'h0,        0, 0, 32'h0,         32'h0,        0, 32'h0,        32'h0,  0);
    row(0, 0, 32'h0,         0, 1, 32'h01,       1, 1, 32'h0,         32'h4,        1, 32'h0,        32'h01, 1);
    row(0, 0, 32'h0,         0, 0, 32'h02,       1, 1, 32'h4,         32'h4,        0, 32'h0,        32'h01, 1);
    row(0, 0, 32'h0,         0, 1, 32'h03,       1, 1, 32'h4,         32'h8,        1, 32'h4,        32'h03, 2);
    row(0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0,        1, 0, 32'h8,         32'hFFFF_FFFC,0, 32'h4,        32'h03, 2);
    row(0, 0, 32'h0,         0, 1, 32'h77,       1, 1, 32'hFFFF_FFFC, 32'h0,        1, 32'hFFFF_FFFC,32'h77, 3);
    row(0, 1, 32'h207,       0, 1, 32'h55,       1, 0, 32'h0,         32'h204,      0, 32'hFFFF_FFFC,32'h77, 3);
    row(0, 0, 32'h0,         0, 0, 32'h0,        1, 1, 32'h204,       32'h204,      0, 32'hFFFF_FFFC,32'h77, 3);
    row(0, 0, 32'h0,         1, 1, 32'h66,       1, 0, 32'h204,       32'h204,      0, 32'hFFFF_FFFC,32'h77, 3);
    row(1, 1, 32'h300,       1, 1, 32'h0,        1, 0, 32'h204,       32'h0,        0, 32'h0,        32'h0,  0);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v.rst, v.red, v.rpc, v.stall, v.gnt, v.data);
      #1;
      check($sformatf("ireq[%0d]", i), {63'h0, ireq}, {63'h0, v.exp_ireq});
      if (v.chk_addr) check($sformatf("iaddr[%0d]", i), {32'h0, iaddr}, {32'h0, v.exp_iaddr});
      e.tag = i; e.pc = v.exp_pc; e.v = v.exp_v;
      e.ifid = {v.exp_ifpc, v.exp_ifin}; e.cnt = v.exp_cnt;
      sb.push_back(e);
      edge_and_compare();
    end

    // Random mix of grants, stalls and redirects against a reference model.
    drive(1, 0, 0, 0, 0, 0);
    m_pc = 0; m_cnt = 0; m_ifid = 0; m_v = 0;
    e.tag = 100; e.pc = m_pc; e.v = m_v; e.ifid = m_ifid; e.cnt = m_cnt;
    sb.push_back(e);
    edge_and_compare();
    for (int i = 0; i < 60; i++) begin
      logic red, stl, gnt;
      logic [31:0] rpc, dat;
      gnt = 1'($urandom_range(0, 3) != 0);
      stl = 1'($urandom_range(0, 3) == 0);
      red = 1'($urandom_range(0, 7) == 0);
      rpc = $urandom;
      dat = $urandom;
      drive(0, red, rpc, stl, gnt, dat);
      #1;
      check($sformatf("rnd_ireq[%0d]", i), {63'h0, ireq}, {63'h0, !stl && !red});
      check($sformatf("rnd_iaddr[%0d]", i), {32'h0, iaddr}, {32'h0, m_pc});
      if (red) begin
        m_pc = {rpc[31:2], 2'b00};
        m_v  = 1'b0;
      end else if (!stl) begin
        if (gnt) begin
          m_ifid = {m_pc, dat};
          m_v    = 1'b1;
          m_pc   = m_pc + 32'd4;
          m_cnt  = m_cnt + 32'd1;
        end else begin
          m_v = 1'b0;
        end
      end
      e.tag = 101 + i; e.pc = m_pc; e.v = m_v; e.ifid = m_ifid; e.cnt = m_cnt;
      sb.push_back(e);
      edge_and_compare();
    end

    // Reset during a stall on the instance with a nonzero reset PC.
    drive(1, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    check("r80_pc_after_reset", {32'h0, iaddr_80}, 64'h80);
    check("r80_valid_after_reset", {63'h0, if_id_valid_80}, 64'h0);
    drive(0, 0, 0, 0, 1, 32'hA1);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 1, 32'hA2);
    @(posedge clk); #1;
    check("r80_pc_after_grants", {32'h0, iaddr_80}, 64'h88);
    check("r80_if_id_after_grants", reg_if_id_80, {32'h84, 32'hA2});
    check("r80_count_after_grants", {32'h0, fetch_count_80}, 64'h2);
    drive(0, 0, 0, 1, 1, 32'hA3);
    @(posedge clk); #1;
    check("r80_if_id_stalled", reg_if_id_80, {32'h84, 32'hA2});
    drive(1, 1, 32'h40, 1, 1, 32'hA4);
    @(posedge clk); #1;
    check("r80_pc_reset_in_stall", {32'h0, iaddr_80}, 64'h80);
    check("r80_valid_reset_in_stall", {63'h0, if_id_valid_80}, 64'h0);
    check("r80_count_reset_in_stall", {32'h0, fetch_count_80}, 64'h0);
    check("r80_if_id_reset_in_stall", reg_if_id_80, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter XLEN, default 32, address and PC width in bits.
REQ-002 Parameter ILEN, default 32, instruction width in bits.
REQ-003 Parameter INSTR_BYTES, default 4, PC increment per fetched instruction; power of two.
REQ-004 Parameter RESET_PC, default 0, PC value loaded on reset; multiple of INSTR_BYTES.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 idata  input  ILEN  instruction word for iaddr; valid in the same cycle igrant=1.
REQ-008 igrant  input  1  memory accepts the request and returns idata this cycle.
REQ-009 id_stall  input  1  decode cannot accept; hold the IF/ID register.
REQ-010 redirect_en  input  1  branch/jump taken; flush and reload the PC.
REQ-011 redirect_pc  input  XLEN  redirect target address.
REQ-012 ireq  output  1  fetch request to instruction memory.
REQ-013 iaddr  output  XLEN  fetch address; equals the current PC.
REQ-014 reg_if_id  output  XLEN+ILEN  IF/ID pipeline register {pc, instr}, PC in the upper XLEN bits.
REQ-015 if_id_valid  output  1  reg_if_id holds a real instruction; 0 marks a bubble.
REQ-016 fetch_count  output  32  number of instructions delivered into IF/ID since reset.

Function
REQ-017 iaddr SHALL equal pc combinationally in every cycle.
REQ-018 ireq SHALL be 1 iff reset=0, id_stall=0 and redirect_en=0.
REQ-019 The per-edge update SHALL apply the first matching rule in this order: reset, redirect, stall, grant, idle.
REQ-020 Redirect, with reset=0 and redirect_en=1:
- pc <= redirect_pc with the low log2(INSTR_BYTES) bits forced to 0;
- if_id_valid <= 0;
- reg_if_id and fetch_count hold;
- applies regardless of id_stall, so redirect wins over stall.
REQ-021 Stall, with redirect_en=0 and id_stall=1: pc, reg_if_id, if_id_valid and fetch_count SHALL all hold.
REQ-022 Grant, with redirect_en=0, id_stall=0 and igrant=1:
- reg_if_id <= {pc, idata};
- if_id_valid <= 1;
- pc <= pc + INSTR_BYTES;
- fetch_count increments by 1.
REQ-023 Idle, with redirect_en=0, id_stall=0 and igrant=0: if_id_valid <= 0 (bubble), pc holds, reg_if_id holds.
REQ-024 PC arithmetic SHALL be modulo 2^XLEN; for XLEN=32, pc=FFFF_FFFC SHALL wrap to 0000_0000 with no error flag.
REQ-025 fetch_count SHALL wrap modulo 2^32.
REQ-026 Fetch-to-IF/ID latency SHALL be exactly 1 cycle; sustained throughput SHALL be 1 instruction per cycle while igrant=1 and there is no stall or redirect.
REQ-027 No instruction SHALL be lost or duplicated across a stall: the instruction held in IF/ID during a stall is delivered exactly once.
REQ-028 An instruction fetched in the same cycle as a redirect SHALL be discarded and SHALL never appear with if_id_valid=1.

Reset
REQ-029 When reset=1 at a rising edge:
- pc <= RESET_PC;
- reg_if_id <= 0;
- if_id_valid <= 0;
- fetch_count <= 0.
REQ-030 Reset SHALL take priority over redirect_en, id_stall and igrant, including reset asserted mid-stall or mid-redirect.
REQ-031 The PC SHALL NOT rely on an initial block for its starting value; reset alone defines it.

Structure
REQ-032 A shared package SHALL hold the XLEN/ILEN/INSTR_BYTES defaults, the RESET_PC default and the IF/ID field layout (PC upper, instruction lower).
REQ-033 Next-PC selection (reset/redirect/hold/increment with alignment mask) SHALL be a sub-module named pc_gen; the IF/ID register, valid bit and counter stay in if_stage.

Verification
REQ-034 Reset, then igrant=1 with idata=0x11,0x22,0x33 on consecutive cycles:
- iaddr = 0,4,8;
- reg_if_id = {0,0x11}, {4,0x22}, {8,0x33}, each one cycle later;
- if_id_valid = 1 throughout;
- fetch_count = 3.
REQ-035 id_stall=1 for 3 cycles while IF/ID = {4,0x22}:
- IF/ID, pc=8 and fetch_count hold;
- ireq = 0;
- after release, {8,idata} is delivered next with no duplicate and no skip.
REQ-036 redirect_en=1, redirect_pc=0x103, with id_stall=1 and igrant=1 in the same cycle:
- next cycle pc = 0x100 and if_id_valid = 0;
- the following grant delivers {0x100,idata}.
REQ-037 igrant toggling 1,0,1:
- if_id_valid = 1,0,1;
- iaddr = 0,4,4,8.
REQ-038 Redirect to 0xFFFF_FFFC, then a grant:
- pc wraps to 0;
- IF/ID PC = 0xFFFF_FFFC.
REQ-039 Reset asserted during a stall with RESET_PC=0x80:
- next cycle pc = 0x80;
- valid = 0;
- fetch_count = 0;
- reg_if_id = 0.
